// File: rtl/sdram_host_bridge.sv
// Command FIFO front-end serialising reads/writes onto the SDRAM controller's level-held req/gnt host port.
// Optional grant watchdog is enabled by defining SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_host_bridge #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_busy,
  output logic                  o_wreq,
  input  logic                  i_wgnt,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_rreq,
  input  logic                  i_rgnt,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [DATA_WIDTH-1:0] i_rdata
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W:0]        r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_holdWe;
  logic [ADDR_WIDTH-1:0] r_holdAddr;
  logic [DATA_WIDTH-1:0] r_holdData;
  logic                  w_grant;
  logic                  w_readGrant;
  logic                  w_timeout;
  logic                  r_rspValid;
  logic [DATA_WIDTH-1:0] r_rspData;
  logic                  r_rspErr;

  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign o_cmd_ready = !i_rst && !w_full;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == IDLE) && !w_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr] <= {i_cmd_we, i_cmd_addr, i_cmd_wdata};
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_holdWe   <= 1'b0;
      r_holdAddr <= '0;
      r_holdData <= '0;
    end else if (w_pop) begin
      {r_holdWe, r_holdAddr, r_holdData} <= r_mem[r_rdPtr];
    end
  end

  assign w_grant     = r_holdWe ? i_wgnt : i_rgnt;
  assign w_readGrant = (r_state == REQ) && !r_holdWe && i_rgnt;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_toCount;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_pop)       r_toCount <= '0;
    else if (r_state == REQ)  r_toCount <= r_toCount + TO_W'(1);
  end

  // A grant arriving on the limit cycle takes priority over the watchdog.
  assign w_timeout = (r_state == REQ) && !w_grant &&
                     (r_toCount == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // GAP keeps requests low for one cycle so a held grant is never counted twice.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (!w_empty) w_nextState = REQ;
      REQ:     if (w_grant || w_timeout) w_nextState = GAP;
      GAP:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    o_wreq = 1'b0;
    o_rreq = 1'b0;
    if (r_state == REQ) begin
      o_wreq = r_holdWe;
      o_rreq = !r_holdWe;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_rspValid <= w_readGrant;
      r_rspErr   <= w_timeout;
      if (w_readGrant) r_rspData <= i_rdata;
    end
  end

  assign o_waddr     = r_holdAddr;
  assign o_raddr     = r_holdAddr;
  assign o_wdata     = r_holdData;
  assign o_rsp_valid = r_rspValid;
  assign o_rsp_data  = r_rspData;
  assign o_rsp_err   = r_rspErr;
  assign o_busy      = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_sdram_host_bridge.sv
// Directed scoreboard testbench for sdram_host_bridge with a behavioural SDRAM controller on the req/gnt port.
`timescale 1ns/1ps
module tb_sdram_host_bridge;

  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic          clk;
  logic          rst;
  logic          cmdValid;
  logic          cmdReady;
  logic          cmdWe;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdWdata;
  logic          rspValid;
  logic [DW-1:0] rspData;
  logic          rspErr;
  logic          busy;
  logic          wreq;
  logic          wgnt;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rreq;
  logic          rgnt;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  logic [DW-1:0] sbQ [$];
  logic [DW-1:0] refMem  [logic [AW-1:0]];
  logic [DW-1:0] ctrlMem [logic [AW-1:0]];
  logic [DW-1:0] expData;

  int checkCount = 0;
  int passCount  = 0;
  int rreqCycles = 0;
  int wreqCycles = 0;
  int rspCount   = 0;
  int errSeen    = 0;
  int errBudget  = 0;
  int grantDelay = 0;
  int waitCnt    = 0;
  int rBefore;
  int wBefore;
  int sBefore;
  bit modelStall = 0;
  bit modelHold  = 0;
  bit granting   = 0;

  sdram_host_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_we(cmdWe),
    .i_cmd_addr(cmdAddr), .i_cmd_wdata(cmdWdata),
    .o_rsp_valid(rspValid), .o_rsp_data(rspData), .o_rsp_err(rspErr), .o_busy(busy),
    .o_wreq(wreq), .i_wgnt(wgnt), .o_waddr(waddr), .o_wdata(wdata),
    .o_rreq(rreq), .i_rgnt(rgnt), .o_raddr(raddr), .i_rdata(rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic logic [DW-1:0] defaultData(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5B5;
  endfunction

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    if (refMem.exists(a)) return refMem[a];
    return defaultData(a);
  endfunction

  function automatic logic [DW-1:0] ctrlRead(input logic [AW-1:0] a);
    if (ctrlMem.exists(a)) return ctrlMem[a];
    return defaultData(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer one command from a negedge and record its expected effect once accepted.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n = 0;
    cmdValid = 1'b1;
    cmdWe    = we;
    cmdAddr  = addr;
    cmdWdata = data;
    while (cmdReady !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cmdReady !== 1'b1) checkOutput("push_accept_timeout", cmdReady, 1);
    else if (we) refMem[addr] = data;
    else sbQ.push_back(refRead(addr));
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, busy, 0);
  endtask

  // Controller model: single-cycle grant after grantDelay request cycles, or grants held high in hold mode.
  initial begin
    wgnt  = 1'b0;
    rgnt  = 1'b0;
    rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (modelHold) begin
        wgnt = 1'b1;
        rgnt = 1'b1;
        if (rreq === 1'b1) rdata = ctrlRead(raddr);
        if (wreq === 1'b1) ctrlMem[waddr] = wdata;
      end else begin
        if (granting) begin
          granting = 0;
          waitCnt  = 0;
        end else if ((wreq === 1'b1 || rreq === 1'b1) && !modelStall) begin
          waitCnt++;
          if (waitCnt > grantDelay) begin
            granting = 1;
            if (wreq === 1'b1) begin
              wgnt = 1'b1;
              ctrlMem[waddr] = wdata;
            end else begin
              rgnt  = 1'b1;
              rdata = ctrlRead(raddr);
            end
          end
        end else if (wreq !== 1'b1 && rreq !== 1'b1) begin
          waitCnt = 0;
        end
        if (!granting) begin
          wgnt  = 1'b0;
          rgnt  = 1'b0;
          rdata = 16'hDEAD;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (rreq === 1'b1) rreqCycles++;
      if (wreq === 1'b1) wreqCycles++;
      if (wreq === 1'b1 && rreq === 1'b1) checkOutput("req_exclusive", wreq & rreq, 0);
      if (rspValid === 1'b1) begin
        rspCount++;
        if (sbQ.size() == 0) checkOutput("rsp_unexpected", rspValid, 0);
        else begin
          expData = sbQ.pop_front();
          checkOutput("rsp_data", rspData, expData);
        end
      end
      if (rspErr === 1'b1) begin
        errSeen++;
        checkOutput("rsp_err", rspErr, errBudget != 0);
        if (errBudget != 0) errBudget--;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdWe    = 1'b0;
    cmdAddr  = '0;
    cmdWdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", cmdReady, 0);
    checkOutput("rst_wreq", wreq, 0);
    checkOutput("rst_rreq", rreq, 0);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_waddr", waddr, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", cmdReady, 1);
    @(negedge clk);

    grantDelay = 0;
    applyStimulus(1'b1, 24'h012345, 16'hBEEF);
    checkOutput("wr_req_not_yet", wreq, 0);
    @(negedge clk);
    checkOutput("wr_wreq", wreq, 1);
    checkOutput("wr_rreq", rreq, 0);
    checkOutput("wr_waddr", waddr, 24'h012345);
    checkOutput("wr_wdata", wdata, 16'hBEEF);
    checkOutput("wr_busy", busy, 1);
    @(negedge clk);
    checkOutput("wr_wreq_drop", wreq, 0);
    checkOutput("wr_no_rsp", rspValid, 0);
    @(negedge clk);
    checkOutput("wr_busy_fall", busy, 0);

    grantDelay = 8;
    rBefore = rreqCycles;
    applyStimulus(1'b0, 24'h000010, 16'h0000);
    for (int n = 0; n < 40 && rspValid !== 1'b1; n++) @(negedge clk);
    checkOutput("rd_rsp_strobe", rspValid, 1);
    checkOutput("rd_rsp_data", rspData, 16'hA5A5);
    checkOutput("rd_rreq_low", rreq, 0);
    checkOutput("rd_req_cycles", rreqCycles - rBefore, 9);
    @(negedge clk);
    checkOutput("rd_rsp_one_cycle", rspValid, 0);
    waitIdle("rd_idle", 20);

    modelStall = 1;
    grantDelay = 1;
    applyStimulus(1'b1, 24'h000100, 16'h1111);
    applyStimulus(1'b0, 24'h000100, 16'h0000);
    applyStimulus(1'b1, 24'h000200, 16'h2222);
    applyStimulus(1'b0, 24'h000200, 16'h0000);
    applyStimulus(1'b0, 24'h000300, 16'h0000);
    checkOutput("fifo_full_ready", cmdReady, 0);
    repeat (3) @(negedge clk);
    checkOutput("fifo_stall_ready", cmdReady, 0);
    checkOutput("fifo_stall_wreq", wreq, 1);
    checkOutput("fifo_head_addr", waddr, 24'h000100);
    modelStall = 0;
    applyStimulus(1'b0, 24'h000500, 16'h0000);
    waitIdle("fifo_drain_idle", 300);
    @(negedge clk);
    checkOutput("fifo_drain_sb", sbQ.size(), 0);

    modelHold = 1;
    repeat (2) @(negedge clk);
    rBefore = rreqCycles;
    sBefore = rspCount;
    applyStimulus(1'b0, 24'h000200, 16'h0000);
    applyStimulus(1'b0, 24'h000200, 16'h0000);
    waitIdle("hold_idle", 50);
    @(negedge clk);
    checkOutput("hold_rreq_cycles", rreqCycles - rBefore, 2);
    checkOutput("hold_rsp_count", rspCount - sBefore, 2);
    modelHold = 0;
    repeat (2) @(negedge clk);

    modelStall = 1;
    applyStimulus(1'b0, 24'h000010, 16'h0000);
    applyStimulus(1'b0, 24'h000020, 16'h0000);
    applyStimulus(1'b0, 24'h000030, 16'h0000);
    applyStimulus(1'b0, 24'h000040, 16'h0000);
    checkOutput("rst_mid_rreq_high", rreq, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_rreq_drop", rreq, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_ready", cmdReady, 0);
    rst = 1'b0;
    sbQ.delete();
    modelStall = 0;
    rBefore = rreqCycles;
    sBefore = rspCount;
    repeat (10) @(negedge clk);
    checkOutput("rst_mid_no_reissue", rreqCycles - rBefore, 0);
    checkOutput("rst_mid_no_rsp", rspCount - sBefore, 0);
    applyStimulus(1'b0, 24'h000010, 16'h0000);
    waitIdle("rst_fresh_idle", 50);
    @(negedge clk);
    checkOutput("rst_fresh_sb", sbQ.size(), 0);

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    modelStall = 1;
    errBudget  = 1;
    rBefore = rreqCycles;
    wBefore = wreqCycles;
    applyStimulus(1'b0, 24'h000600, 16'h0000);
    void'(sbQ.pop_back());
    applyStimulus(1'b1, 24'h000700, 16'h7777);
    for (int n = 0; n < 100 && rspErr !== 1'b1; n++) @(negedge clk);
    checkOutput("to_err_pulse", rspErr, 1);
    checkOutput("to_no_rsp_valid", rspValid, 0);
    checkOutput("to_req_cycles", rreqCycles - rBefore, TO);
    modelStall = 0;
    @(negedge clk);
    checkOutput("to_err_one_cycle", rspErr, 0);
    waitIdle("to_next_idle", 50);
    checkOutput("to_write_issued", wreqCycles - wBefore, 2);
    applyStimulus(1'b0, 24'h000700, 16'h0000);
    waitIdle("to_readback_idle", 50);
`else
    modelStall = 1;
    applyStimulus(1'b0, 24'h000600, 16'h0000);
    void'(sbQ.pop_back());
    repeat (40) @(negedge clk);
    checkOutput("nto_rreq_held", rreq, 1);
    checkOutput("nto_no_err", errSeen, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelStall = 0;
    @(negedge clk);
`endif

    @(negedge clk);
    checkOutput("final_sb_empty", sbQ.size(), 0);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
